// File: rtl/sram_array_pkg.sv
// Shared types and elaboration helpers for the masked single-port SRAM array controller.
package sram_array_pkg;

    typedef enum logic {
        INIT  = 1'b0,
        READY = 1'b1
    } state_e;

    function automatic int unsigned lane_w(input int unsigned data_w, input int unsigned mask_w);
        return data_w / mask_w;
    endfunction

    // Legal geometry: whole lanes, at least two entries, and every entry addressable.
    function automatic bit cfg_ok(input int unsigned depth, input int unsigned addr_w,
                                  input int unsigned data_w, input int unsigned mask_w);
        bit ok;
        ok = (mask_w != 0) && (data_w != 0) && (addr_w != 0) && (depth >= 2);
        if (ok) ok = ((data_w % mask_w) == 0);
        if (ok && (addr_w < 32)) ok = (depth <= (32'd1 << addr_w));
        return ok;
    endfunction

endpackage

// File: rtl/sram_array_core.sv
// Behavioural DEPTH x DATA_W storage with per-lane masked write and a registered read port.
module sram_array_core
    import sram_array_pkg::*;
#(
    parameter int unsigned DEPTH  = 128,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 74,
    parameter int unsigned MASK_W = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [MASK_W-1:0] wmask_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              rd_zero_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int unsigned LANE_W = lane_w(DATA_W, MASK_W);
    localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic [IDX_W-1:0]  idx_c;

    assign idx_c = IDX_W'(addr_i);

    // Storage is intentionally not reset; contents come from the controller's sweep.
    always_ff @(posedge clk) begin
        if (we_i) begin
            for (int l = 0; l < int'(MASK_W); l++) begin
                if (wmask_i[l]) begin
                    mem_q[idx_c][l*LANE_W +: LANE_W] <= wdata_i[l*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Read register only loads on a read, so it doubles as the hold-last-data register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= rd_zero_i ? '0 : mem_q[idx_c];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sram_array_ctrl.sv
// Request/response front end for the SRAM array: post-reset zero sweep, bounds check,
// response pipeline with optional output register and hold-last-data behaviour.
module sram_array_ctrl
    import sram_array_pkg::*;
#(
    parameter int unsigned DEPTH     = 128,
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 74,
    parameter int unsigned MASK_W    = 2,
    parameter int unsigned OUT_REG   = 0,
    parameter int unsigned INIT_ZERO = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [MASK_W-1:0] req_wmask,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              init_done
);

    if (!cfg_ok(DEPTH, ADDR_W, DATA_W, MASK_W)) begin : g_cfg_err
        $error("sram_array_ctrl: illegal DEPTH/ADDR_W/DATA_W/MASK_W combination");
    end

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W + 1)'(DEPTH);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  init_cnt_q, init_cnt_d;
    logic               ready_c, done_c, sweep_c;

    // State register and sweep counter.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    // Next state: sweep one entry per cycle, stop on the last entry; skip when zeroing is off.
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        case (state_q)
            INIT: begin
                if (INIT_ZERO == 0) begin
                    state_d = READY;
                end else if (init_cnt_q == LAST_IDX) begin
                    state_d = READY;
                end else begin
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
                end
            end
            READY: state_d = READY;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        ready_c = 1'b0;
        done_c  = 1'b0;
        sweep_c = 1'b0;
        if (state_q == READY) begin
            ready_c = 1'b1;
            done_c  = 1'b1;
        end else begin
            sweep_c = (INIT_ZERO != 0);
        end
    end

    assign req_ready = ready_c;
    assign init_done = done_c;

    logic              hs_c, in_range_c, rd_hs_c;
    logic              core_we_c, core_re_c;
    logic [ADDR_W-1:0] core_addr_c;
    logic [MASK_W-1:0] core_wmask_c;
    logic [DATA_W-1:0] core_wdata_c;
    logic [DATA_W-1:0] core_rdata;

    // Storage port mux: the sweep owns the array until READY.
    always_comb begin
        hs_c         = req_valid & ready_c;
        in_range_c   = ({1'b0, req_addr} < DEPTH_EXT);
        rd_hs_c      = hs_c & ~req_write;
        core_we_c    = hs_c & req_write & in_range_c;
        core_re_c    = rd_hs_c;
        core_addr_c  = req_addr;
        core_wmask_c = req_wmask;
        core_wdata_c = req_wdata;
        if (sweep_c) begin
            core_we_c    = 1'b1;
            core_re_c    = 1'b0;
            core_addr_c  = init_cnt_q;
            core_wmask_c = '1;
            core_wdata_c = '0;
        end
    end

    sram_array_core #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .MASK_W (MASK_W)
    ) u_core (
        .clk       (clock),
        .rst_n     (reset_n),
        .we_i      (core_we_c),
        .re_i      (core_re_c),
        .addr_i    (core_addr_c),
        .wmask_i   (core_wmask_c),
        .wdata_i   (core_wdata_c),
        .rd_zero_i (~in_range_c),
        .rdata_o   (core_rdata)
    );

    logic s1_valid_q, s1_err_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_err_q   <= 1'b0;
        end else begin
            s1_valid_q <= rd_hs_c;
            s1_err_q   <= rd_hs_c & ~in_range_c;
        end
    end

    if (OUT_REG != 0) begin : g_out_reg
        logic              s2_valid_q, s2_err_q;
        logic [DATA_W-1:0] s2_rdata_q;

        // Second stage keeps its own hold register, loaded only by a valid response.
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                s2_valid_q <= 1'b0;
                s2_err_q   <= 1'b0;
                s2_rdata_q <= '0;
            end else begin
                s2_valid_q <= s1_valid_q;
                s2_err_q   <= s1_err_q;
                if (s1_valid_q) s2_rdata_q <= core_rdata;
            end
        end

        assign resp_valid = s2_valid_q;
        assign resp_err   = s2_err_q;
        assign resp_rdata = s2_rdata_q;
    end else begin : g_no_out_reg
        assign resp_valid = s1_valid_q;
        assign resp_err   = s1_err_q;
        assign resp_rdata = core_rdata;
    end

endmodule

// File: tb/tb_sram_array_ctrl.sv
// Directed bench: three controller instances (latency 1, latency 2, DEPTH=100 without sweep).
module tb_sram_array_ctrl;

    localparam int unsigned DW = 74;
    localparam int unsigned AW = 7;
    localparam int unsigned MW = 2;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};
    localparam logic [DW-1:0] EXP2 = {{37{1'b1}}, {37{1'b0}}};

    logic          clock;
    logic          reset_n;
    logic          a_valid, a_write, b_valid, b_write;
    logic [AW-1:0] a_addr, b_addr;
    logic [MW-1:0] a_wmask, b_wmask;
    logic [DW-1:0] a_wdata, b_wdata;

    logic          r0_ready, r0_rv, r0_err, r0_done;
    logic          r1_ready, r1_rv, r1_err, r1_done;
    logic          r2_ready, r2_rv, r2_err, r2_done;
    logic [DW-1:0] r0_rd, r1_rd, r2_rd;

    int checks = 0;
    int errors = 0;

    sram_array_ctrl #(.DEPTH(128), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .OUT_REG(0), .INIT_ZERO(1)) u0 (
        .clock(clock), .reset_n(reset_n), .req_valid(a_valid), .req_ready(r0_ready),
        .req_write(a_write), .req_addr(a_addr), .req_wmask(a_wmask), .req_wdata(a_wdata),
        .resp_valid(r0_rv), .resp_rdata(r0_rd), .resp_err(r0_err), .init_done(r0_done));

    sram_array_ctrl #(.DEPTH(128), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .OUT_REG(1), .INIT_ZERO(1)) u1 (
        .clock(clock), .reset_n(reset_n), .req_valid(a_valid), .req_ready(r1_ready),
        .req_write(a_write), .req_addr(a_addr), .req_wmask(a_wmask), .req_wdata(a_wdata),
        .resp_valid(r1_rv), .resp_rdata(r1_rd), .resp_err(r1_err), .init_done(r1_done));

    sram_array_ctrl #(.DEPTH(100), .ADDR_W(AW), .DATA_W(DW), .MASK_W(MW), .OUT_REG(0), .INIT_ZERO(0)) u2 (
        .clock(clock), .reset_n(reset_n), .req_valid(b_valid), .req_ready(r2_ready),
        .req_write(b_write), .req_addr(b_addr), .req_wmask(b_wmask), .req_wdata(b_wdata),
        .resp_valid(r2_rv), .resp_rdata(r2_rd), .resp_err(r2_err), .init_done(r2_done));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_d(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_i(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic drv_a(input logic v, input logic w, input logic [AW-1:0] ad,
                         input logic [MW-1:0] m, input logic [DW-1:0] d);
        a_valid = v; a_write = w; a_addr = ad; a_wmask = m; a_wdata = d;
    endtask

    task automatic drv_b(input logic v, input logic w, input logic [AW-1:0] ad,
                         input logic [MW-1:0] m, input logic [DW-1:0] d);
        b_valid = v; b_write = w; b_addr = ad; b_wmask = m; b_wdata = d;
    endtask

    int            n0, n1, nr;
    logic [DW-1:0] or0, or1;
    logic          e0, e1;

    initial begin
        reset_n = 1'b0;
        drv_a(1'b0, 1'b0, '0, '0, '0);
        drv_b(1'b0, 1'b0, '0, '0, '0);
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_b("rst_ready0", r0_ready, 1'b0);
        chk_b("rst_done0", r0_done, 1'b0);
        chk_b("rst_rv1", r1_rv, 1'b0);
        chk_d("rst_rdata1", r1_rd, '0);
        chk_b("rst_ready2", r2_ready, 1'b0);
        chk_b("rst_done2", r2_done, 1'b0);

        // Sweep timing; writes offered during INIT must be ignored.
        @(posedge clock); #1 reset_n = 1'b1;
        cyc(); drv_a(1'b1, 1'b1, 7'd7, 2'b11, ONES);
        @(negedge clock);
        chk_b("noinit_ready2", r2_ready, 1'b1);
        chk_b("noinit_done2", r2_done, 1'b1);
        chk_b("sweep_ready0", r0_ready, 1'b0);
        repeat (98) @(posedge clock);
        #1 drv_a(1'b0, 1'b0, '0, '0, '0);
        repeat (27) @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        chk_b("done_at127_0", r0_done, 1'b0);
        chk_b("done_at127_1", r1_done, 1'b0);
        @(posedge clock);
        @(negedge clock);
        chk_b("done_at128_0", r0_done, 1'b1);
        chk_b("done_at128_1", r1_done, 1'b1);
        chk_b("ready_at128_0", r0_ready, 1'b1);

        // Read every entry back-to-back.
        n0 = 0; n1 = 0; or0 = '0; or1 = '0; e0 = 1'b0; e1 = 1'b0;
        for (int i = 0; i < 130; i++) begin
            cyc();
            if (i < 128) drv_a(1'b1, 1'b0, AW'(i), '0, '0);
            else         drv_a(1'b0, 1'b0, '0, '0, '0);
            @(negedge clock);
            if (r0_rv) begin n0++; or0 |= r0_rd; e0 |= r0_err; end
            if (r1_rv) begin n1++; or1 |= r1_rd; e1 |= r1_err; end
        end
        chk_i("sweep_nresp0", n0, 128);
        chk_i("sweep_nresp1", n1, 128);
        chk_d("sweep_data0", or0, '0);
        chk_d("sweep_data1", or1, '0);
        chk_b("sweep_err0", e0, 1'b0);
        chk_b("sweep_err1", e1, 1'b0);

        // Masked write.
        cyc(); drv_a(1'b1, 1'b1, 7'd5, 2'b11, ONES);
        cyc(); drv_a(1'b1, 1'b1, 7'd5, 2'b01, '0);
        cyc(); drv_a(1'b1, 1'b0, 7'd5, '0, '0);
        cyc(); drv_a(1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
        chk_b("mask_rv0", r0_rv, 1'b1);
        chk_d("mask_rd0", r0_rd, EXP2);
        chk_b("mask_rv1_early", r1_rv, 1'b0);
        cyc(); @(negedge clock);
        chk_b("mask_rv1", r1_rv, 1'b1);
        chk_d("mask_rd1", r1_rd, EXP2);
        chk_b("mask_rv0_after", r0_rv, 1'b0);
        chk_d("mask_hold0", r0_rd, EXP2);

        // Entry 7 was targeted only during INIT.
        cyc(); drv_a(1'b1, 1'b0, 7'd7, '0, '0);
        cyc(); drv_a(1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
        chk_b("init_ign_rv0", r0_rv, 1'b1);
        chk_d("init_ign_rd0", r0_rd, '0);
        cyc(); @(negedge clock);
        chk_d("init_ign_rd1", r1_rd, '0);

        // Back-to-back write/read/read.
        cyc(); drv_a(1'b1, 1'b1, 7'd3, 2'b11, 74'h1234);
        cyc(); drv_a(1'b1, 1'b0, 7'd3, '0, '0);
        cyc(); drv_a(1'b1, 1'b0, 7'd4, '0, '0);
        @(negedge clock);
        chk_b("b2b_rv0_a", r0_rv, 1'b1);
        chk_d("b2b_rd0_a", r0_rd, 74'h1234);
        cyc(); drv_a(1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
        chk_b("b2b_rv0_b", r0_rv, 1'b1);
        chk_d("b2b_rd0_b", r0_rd, '0);
        chk_b("b2b_rv1_a", r1_rv, 1'b1);
        chk_d("b2b_rd1_a", r1_rd, 74'h1234);
        cyc(); @(negedge clock);
        chk_b("b2b_rv0_c", r0_rv, 1'b0);
        chk_d("b2b_hold0", r0_rd, '0);
        chk_b("b2b_err0", r0_err, 1'b0);
        chk_b("b2b_rv1_b", r1_rv, 1'b1);
        chk_d("b2b_rd1_b", r1_rd, '0);
        cyc(); @(negedge clock);
        chk_b("b2b_rv1_c", r1_rv, 1'b0);
        chk_d("b2b_hold1", r1_rd, '0);

        // DEPTH=100 instance: latency-1 write/read and out-of-range handling.
        cyc(); drv_b(1'b1, 1'b1, 7'd0, 2'b11, 74'habc);
        cyc(); drv_b(1'b1, 1'b0, 7'd0, '0, '0);
        cyc(); drv_b(1'b1, 1'b1, 7'd99, 2'b11, 74'h55);
        @(negedge clock);
        chk_b("u2_rv_a0", r2_rv, 1'b1);
        chk_d("u2_rd_a0", r2_rd, 74'habc);
        chk_b("u2_err_a0", r2_err, 1'b0);
        cyc(); drv_b(1'b1, 1'b1, 7'd110, 2'b11, ONES);
        @(negedge clock);
        chk_b("u2_rv_wr", r2_rv, 1'b0);
        cyc(); drv_b(1'b1, 1'b0, 7'd110, '0, '0);
        cyc(); drv_b(1'b1, 1'b0, 7'd99, '0, '0);
        @(negedge clock);
        chk_b("oor_rv", r2_rv, 1'b1);
        chk_b("oor_err", r2_err, 1'b1);
        chk_d("oor_rd", r2_rd, '0);
        cyc(); drv_b(1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
        chk_b("a99_rv", r2_rv, 1'b1);
        chk_b("a99_err", r2_err, 1'b0);
        chk_d("a99_rd", r2_rd, 74'h55);
        cyc(); @(negedge clock);
        chk_b("u2_idle_rv", r2_rv, 1'b0);
        chk_b("u2_idle_err", r2_err, 1'b0);
        chk_d("u2_hold", r2_rd, 74'h55);

        // Reset with reads in flight, then again mid-sweep at count 40.
        cyc(); drv_a(1'b1, 1'b1, 7'd9, 2'b11, ONES);
        cyc(); drv_a(1'b1, 1'b0, 7'd9, '0, '0);
        cyc(); drv_a(1'b0, 1'b0, '0, '0, '0);
        reset_n = 1'b0;
        @(negedge clock);
        chk_b("rst_fly_rv0", r0_rv, 1'b0);
        chk_d("rst_fly_rd0", r0_rd, '0);
        chk_b("rst_fly_done0", r0_done, 1'b0);
        nr = 0;
        repeat (3) begin
            cyc(); @(negedge clock);
            if (r1_rv) nr++;
        end
        cyc();
        reset_n = 1'b1;
        drv_a(1'b1, 1'b0, 7'd9, '0, '0);
        for (int k = 1; k <= 40; k++) begin
            @(posedge clock); #1;
            if (k == 40) reset_n = 1'b0;
            @(negedge clock);
            if (r0_rv || r1_rv) nr++;
        end
        chk_b("mid_rst_done0", r0_done, 1'b0);
        cyc(); cyc();
        reset_n = 1'b1;
        for (int k = 1; k <= 127; k++) begin
            @(posedge clock); #1;
            if (k == 127) drv_a(1'b0, 1'b0, '0, '0, '0);
            @(negedge clock);
            if (r0_rv || r1_rv) nr++;
        end
        chk_b("resweep_done127_0", r0_done, 1'b0);
        chk_b("resweep_ready127_1", r1_ready, 1'b0);
        @(posedge clock); #1;
        @(negedge clock);
        chk_b("resweep_done128_0", r0_done, 1'b1);
        chk_b("resweep_done128_1", r1_done, 1'b1);
        chk_i("init_no_resp", nr, 0);

        cyc(); drv_a(1'b1, 1'b0, 7'd9, '0, '0);
        cyc(); drv_a(1'b1, 1'b0, 7'd5, '0, '0);
        cyc(); drv_a(1'b0, 1'b0, '0, '0, '0);
        @(negedge clock);
        chk_b("post_rst_rv0_a", r0_rv, 1'b1);
        chk_d("post_rst_rd0_a", r0_rd, '0);
        chk_b("post_rst_rv1_a", r1_rv, 1'b1);
        chk_d("post_rst_rd1_a", r1_rd, '0);
        cyc(); @(negedge clock);
        chk_b("post_rst_rv1_b", r1_rv, 1'b1);
        chk_d("post_rst_rd1_b", r1_rd, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
